// File: rtl/transmit_state_machine_pkg.sv
// Shared eUSCI UART definitions: TX state encoding, frame-size and parity constants,
// and small helpers used to set up a frame.
package transmit_state_machine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5,
    ST_EOF    = 3'd6
  } tx_state_e;

  localparam logic [3:0] DATA8              = 4'd8;
  localparam logic [3:0] DATA7              = 4'd7;
  localparam logic       PAR_ODD            = 1'b0;
  localparam logic       PAR_EVEN           = 1'b1;
  localparam logic       IDLE_LEVEL_DEFAULT = 1'b1;

  function automatic logic [2:0] last_data_index(input logic is_7bit);
    logic [3:0] w_len;
    w_len = is_7bit ? DATA7 : DATA8;
    w_len = w_len - 4'd1;
    return w_len[2:0];
  endfunction

  // Odd parity sets the bit when the data carries an even number of ones.
  function automatic logic parity_bit(input logic data_xor, input logic par_sel);
    logic w_bit;
    case (par_sel)
      PAR_EVEN: w_bit = data_xor;
      PAR_ODD:  w_bit = ~data_xor;
      default:  w_bit = ~data_xor;
    endcase
    return w_bit;
  endfunction

  // MSB-first 7-bit frames are pre-aligned so the first bit sent always sits at [7].
  function automatic logic [7:0] frame_shift_init(input logic [7:0] data,
                                                  input logic       msb_first,
                                                  input logic       is_7bit);
    logic [7:0] w_init;
    if (is_7bit) begin
      w_init = msb_first ? {data[6:0], 1'b0} : {1'b0, data[6:0]};
    end else begin
      w_init = data;
    end
    return w_init;
  endfunction

endpackage

// File: rtl/transmit_state_machine_bitclk_edge_detect.sv
// BITCLK rising-edge detector: one MCLK-wide tick per baud boundary, shared by TX and RX paths.
module transmit_state_machine_bitclk_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_bitclk,
  output logic o_tick
);

  logic r_bclk_q;

  // One-MCLK delayed copy of BITCLK for rise detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bclk_q <= 1'b0;
    end else begin
      r_bclk_q <= i_bitclk;
    end
  end

  assign o_tick = i_bitclk & ~r_bclk_q;

endmodule

// File: rtl/transmit_state_machine.sv
// eUSCI UART transmit state machine: loads the TX buffer and serialises start/data/parity/stop
// on BITCLK ticks. Optional macro TX_BREAK_EN adds wUCTXBRK (all-zero data/parity frames).
module transmit_state_machine
  import transmit_state_machine_pkg::*;
#(
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic       MCLK,
  input  logic       reset,
  input  logic       BITCLK,
  input  logic       wUCPEN,
  input  logic       wUCPAR,
  input  logic       wUCMSB,
  input  logic       wUC7BIT,
  input  logic       wUCSPB,
  input  logic [7:0] TxData,
  input  logic       TxIFG,
`ifdef TX_BREAK_EN
  input  logic       wUCTXBRK,
`endif
  output logic       Tx,
  output logic       TxBEN,
  output logic       rSetTxIFG,
  output logic       TxBusy
);

  logic       w_tick;
  logic       w_brk_in;
  logic       w_load;
  logic       w_data_bit;

  tx_state_e  r_state, w_state_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [2:0] r_bitcnt, w_bitcnt_nxt;
  logic       r_par_acc, w_par_acc_nxt;
  logic       r_tx, w_tx_nxt;
  logic       r_ben, w_ben_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_set_ifg, w_set_ifg_nxt;

  // Frame configuration captured at load so later register writes cannot disturb it.
  logic       r_pen, r_par, r_msb, r_7bit, r_spb, r_brk;

  transmit_state_machine_bitclk_edge_detect u_edge (
    .i_clk    (MCLK),
    .i_rst_n  (reset),
    .i_bitclk (BITCLK),
    .o_tick   (w_tick)
  );

`ifdef TX_BREAK_EN
  assign w_brk_in = wUCTXBRK;
`else
  assign w_brk_in = 1'b0;
`endif

  // Next-state, datapath and output decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bitcnt_nxt  = r_bitcnt;
    w_par_acc_nxt = r_par_acc;
    w_tx_nxt      = r_tx;
    w_ben_nxt     = r_ben;
    w_busy_nxt    = r_busy;
    w_set_ifg_nxt = 1'b0;
    w_load        = 1'b0;
    w_data_bit    = r_msb ? r_shift[7] : r_shift[0];

    case (r_state)
      ST_IDLE: begin
        if (!TxIFG) begin
          w_load      = 1'b1;
          w_state_nxt = ST_START;
        end else begin
          w_tx_nxt   = IDLE_LEVEL;
          w_ben_nxt  = 1'b0;
          w_busy_nxt = 1'b0;
        end
      end

      ST_START: begin
        if (w_tick) begin
          w_tx_nxt      = ~IDLE_LEVEL;
          w_bitcnt_nxt  = last_data_index(r_7bit);
          w_par_acc_nxt = 1'b0;
          w_state_nxt   = ST_DATA;
        end else begin
          w_state_nxt = ST_START;
        end
      end

      ST_DATA: begin
        if (w_tick) begin
          w_tx_nxt      = w_data_bit;
          w_par_acc_nxt = r_par_acc ^ w_data_bit;
          w_shift_nxt   = r_msb ? {r_shift[6:0], 1'b0} : {1'b0, r_shift[7:1]};
          if (r_bitcnt == 3'd0) begin
            if (r_pen) begin
              w_state_nxt = ST_PARITY;
            end else begin
              w_state_nxt = ST_STOP1;
            end
          end else begin
            w_bitcnt_nxt = r_bitcnt - 3'd1;
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end

      ST_PARITY: begin
        if (w_tick) begin
          w_tx_nxt    = r_brk ? 1'b0 : parity_bit(r_par_acc, r_par);
          w_state_nxt = ST_STOP1;
        end else begin
          w_state_nxt = ST_PARITY;
        end
      end

      ST_STOP1: begin
        if (w_tick) begin
          w_tx_nxt = IDLE_LEVEL;
          if (r_spb) begin
            w_state_nxt = ST_STOP2;
          end else begin
            w_state_nxt = ST_EOF;
          end
        end else begin
          w_state_nxt = ST_STOP1;
        end
      end

      ST_STOP2: begin
        if (w_tick) begin
          w_tx_nxt    = IDLE_LEVEL;
          w_state_nxt = ST_EOF;
        end else begin
          w_state_nxt = ST_STOP2;
        end
      end

      // Last stop bit is on the line; the next tick closes it or starts the next frame.
      ST_EOF: begin
        if (w_tick) begin
          if (!TxIFG) begin
            w_load        = 1'b1;
            w_tx_nxt      = ~IDLE_LEVEL;
            w_bitcnt_nxt  = last_data_index(wUC7BIT);
            w_par_acc_nxt = 1'b0;
            w_state_nxt   = ST_DATA;
          end else begin
            w_tx_nxt    = IDLE_LEVEL;
            w_ben_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_EOF;
        end
      end

      default: begin
        w_tx_nxt    = IDLE_LEVEL;
        w_ben_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_load) begin
      w_shift_nxt   = w_brk_in ? 8'h00 : frame_shift_init(TxData, wUCMSB, wUC7BIT);
      w_set_ifg_nxt = 1'b1;
      w_ben_nxt     = 1'b1;
      w_busy_nxt    = 1'b1;
    end else begin
      w_set_ifg_nxt = 1'b0;
    end
  end

  // State, datapath, shadow configuration and registered outputs.
  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= 8'h00;
      r_bitcnt  <= 3'd0;
      r_par_acc <= 1'b0;
      r_tx      <= IDLE_LEVEL;
      r_ben     <= 1'b0;
      r_busy    <= 1'b0;
      r_set_ifg <= 1'b0;
      r_pen     <= 1'b0;
      r_par     <= 1'b0;
      r_msb     <= 1'b0;
      r_7bit    <= 1'b0;
      r_spb     <= 1'b0;
      r_brk     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_par_acc <= w_par_acc_nxt;
      r_tx      <= w_tx_nxt;
      r_ben     <= w_ben_nxt;
      r_busy    <= w_busy_nxt;
      r_set_ifg <= w_set_ifg_nxt;
      if (w_load) begin
        r_pen  <= wUCPEN;
        r_par  <= wUCPAR;
        r_msb  <= wUCMSB;
        r_7bit <= wUC7BIT;
        r_spb  <= wUCSPB;
        r_brk  <= w_brk_in;
      end
    end
  end

  assign Tx        = r_tx;
  assign TxBEN     = r_ben;
  assign rSetTxIFG = r_set_ifg;
  assign TxBusy    = r_busy;

endmodule

// File: tb/tb_transmit_state_machine.sv
// Directed + randomised bench for transmit_state_machine; expected frames come from a
// bit-list model built from the frame format (start, data, parity, stop).
module tb_transmit_state_machine;

  logic       MCLK = 1'b0;
  logic       reset, BITCLK, TxIFG;
  logic       wUCPEN, wUCPAR, wUCMSB, wUC7BIT, wUCSPB;
  logic [7:0] TxData;
  logic       Tx, TxBEN, rSetTxIFG, TxBusy;

  int n_chk   = 0;
  int n_pass  = 0;
  int n_pulse = 0;
  bit exp_q[$];

  transmit_state_machine #(.IDLE_LEVEL(1'b1)) dut (
    .MCLK      (MCLK),
    .reset     (reset),
    .BITCLK    (BITCLK),
    .wUCPEN    (wUCPEN),
    .wUCPAR    (wUCPAR),
    .wUCMSB    (wUCMSB),
    .wUC7BIT   (wUC7BIT),
    .wUCSPB    (wUCSPB),
    .TxData    (TxData),
    .TxIFG     (TxIFG),
`ifdef TX_BREAK_EN
    .wUCTXBRK  (1'b0),
`endif
    .Tx        (Tx),
    .TxBEN     (TxBEN),
    .rSetTxIFG (rSetTxIFG),
    .TxBusy    (TxBusy)
  );

  always #5 MCLK = ~MCLK;

  always @(posedge MCLK) begin
    if (rSetTxIFG === 1'b1) n_pulse <= n_pulse + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Frame model: the list of line levels seen on successive ticks.
  task automatic build_frame(input logic [7:0] d, input logic pen, input logic par,
                             input logic msb, input logic b7, input logic spb);
    int n, ones, idx;
    exp_q.delete();
    exp_q.push_back(1'b0);
    n = b7 ? 7 : 8;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      idx = msb ? (n - 1 - i) : i;
      exp_q.push_back(d[idx]);
      if (d[idx]) ones++;
    end
    if (pen) begin
      if (par) exp_q.push_back((ones % 2) == 1);
      else     exp_q.push_back((ones % 2) == 0);
    end
    exp_q.push_back(1'b1);
    if (spb) exp_q.push_back(1'b1);
  endtask

  task automatic tick();
    repeat ($urandom_range(0, 2)) @(negedge MCLK);
    @(negedge MCLK) BITCLK = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge MCLK);
    BITCLK = 1'b1;
    @(posedge MCLK);
    #1;
  endtask

  task automatic scramble();
    {wUCPEN, wUCPAR, wUCMSB, wUC7BIT, wUCSPB} = 5'($urandom);
    TxData = 8'($urandom);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic pen,
                           input logic par, input logic msb, input logic b7,
                           input logic spb, input logic coincide);
    int p0;
    build_frame(d, pen, par, msb, b7, spb);
    p0 = n_pulse;
    @(negedge MCLK) BITCLK = 1'b0;
    @(negedge MCLK);
    TxData = d; wUCPEN = pen; wUCPAR = par; wUCMSB = msb; wUC7BIT = b7; wUCSPB = spb;
    TxIFG = 1'b0;
    if (coincide) BITCLK = 1'b1;
    @(posedge MCLK);
    #1;
    chk($sformatf("%s/load_set", tag), rSetTxIFG, 8'd1);
    chk($sformatf("%s/load_ben_busy", tag), {TxBEN, TxBusy}, 8'd3);
    chk($sformatf("%s/load_tx_idle", tag), Tx, 8'd1);
    @(negedge MCLK);
    TxIFG = 1'b1;
    scramble();
    @(posedge MCLK);
    #1;
    chk($sformatf("%s/set_width", tag), rSetTxIFG, 8'd0);
    if (coincide) begin
      repeat (3) @(posedge MCLK);
      #1;
      chk($sformatf("%s/start_waits", tag), Tx, 8'd1);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      chk($sformatf("%s/bit%0d", tag, i), Tx, 8'(exp_q[i]));
      chk($sformatf("%s/busy%0d", tag, i), TxBusy, 8'd1);
    end
    tick();
    chk($sformatf("%s/eof_tx_busy_ben", tag), {Tx, TxBusy, TxBEN}, 8'd4);
    chk($sformatf("%s/pulses", tag), 8'(n_pulse - p0), 8'd1);
  endtask

  initial begin
    logic [5:0] rc;
    int p0;
    reset = 1'b0; BITCLK = 1'b0; TxIFG = 1'b1; TxData = 8'h00;
    {wUCPEN, wUCPAR, wUCMSB, wUC7BIT, wUCSPB} = 5'b00000;
    repeat (3) @(posedge MCLK);
    #1;
    chk("reset_outputs", {Tx, TxBEN, rSetTxIFG, TxBusy}, 8'h8);
    @(negedge MCLK) reset = 1'b1;
    repeat (2) @(posedge MCLK);
    #1;
    chk("idle_after_reset", {Tx, TxBEN, rSetTxIFG, TxBusy}, 8'h8);

    run_frame("8N1_A5",  8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame("8O2_55",  8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame("8O2_A4",  8'hA4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame("8E1M_34", 8'h34, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame("7N1_DA",  8'hDA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      rc = 6'($urandom);
      run_frame($sformatf("rnd%0d", k), 8'($urandom), rc[0], rc[1], rc[2], rc[3], rc[4], rc[5]);
    end

    // Back-to-back: TxIFG held low across two frames.
    p0 = n_pulse;
    @(negedge MCLK) BITCLK = 1'b0;
    @(negedge MCLK);
    TxData = 8'h1F; {wUCPEN, wUCPAR, wUCMSB, wUC7BIT, wUCSPB} = 5'b00000;
    TxIFG = 1'b0;
    @(posedge MCLK);
    #1;
    chk("b2b/load1_set", rSetTxIFG, 8'd1);
    @(negedge MCLK) TxData = 8'hF0;
    build_frame(8'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      chk($sformatf("b2b/f1_bit%0d", i), Tx, 8'(exp_q[i]));
    end
    tick();
    chk("b2b/start2_tx_set_busy", {Tx, rSetTxIFG, TxBusy}, 8'd3);
    @(negedge MCLK) TxIFG = 1'b1;
    build_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < exp_q.size(); i++) begin
      tick();
      chk($sformatf("b2b/f2_bit%0d", i), Tx, 8'(exp_q[i]));
    end
    tick();
    chk("b2b/eof_busy", TxBusy, 8'd0);
    chk("b2b/pulses", 8'(n_pulse - p0), 8'd2);

    // Asynchronous abort while a zero data bit is on the line.
    @(negedge MCLK) BITCLK = 1'b0;
    @(negedge MCLK);
    TxData = 8'h00; TxIFG = 1'b0;
    @(posedge MCLK);
    #1;
    @(negedge MCLK) TxIFG = 1'b1;
    repeat (3) tick();
    chk("abort/pre_tx", Tx, 8'd0);
    #2 reset = 1'b0;
    #1;
    chk("abort/tx_busy_ben", {Tx, TxBusy, TxBEN}, 8'd4);
    @(negedge MCLK) reset = 1'b1;
    repeat (3) tick();
    chk("abort/stays_idle", {Tx, TxBusy, TxBEN, rSetTxIFG}, 8'h8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/transmit_state_machine.md
Name: transmit_state_machine

Overview:
eUSCI UART transmit path, the counterpart of the receive state machine. It takes a byte from the TX buffer when the buffer holds unsent data and serializes one frame on Tx: start bit, 7 or 8 data bits LSB- or MSB-first, optional odd/even parity, then 1 or 2 stop bits. It is paced by BITCLK from the baud-rate generator and returns buffer-empty status through a one-cycle TxIFG set pulse.

Parameters:
IDLE_LEVEL, 1'b1, Tx level while idle and during stop bits; the start bit is its complement.

Ports:
MCLK  input  1  system clock; all logic is clocked here.
reset  input  1  asynchronous, active-low reset (asserted when 0).
BITCLK  input  1  baud clock from the baud-rate generator, level input; a rising edge (sampled on MCLK) marks a bit boundary.
wUCPEN  input  1  parity enable.
wUCPAR  input  1  parity select: 0 = odd, 1 = even.
wUCMSB  input  1  1 = MSB first.
wUC7BIT  input  1  1 = 7-bit data, using TxData[6:0].
wUCSPB  input  1  1 = two stop bits.
TxData  input  8  TX buffer contents.
TxIFG  input  1  current TX interrupt flag; 0 = buffer holds unsent data.
Tx  output  1  serial line.
TxBEN  output  1  baud-generator enable; high while a frame is pending or in progress.
rSetTxIFG  output  1  one-MCLK pulse when TxData is loaded, meaning the buffer is now free.
TxBusy  output  1  high from load until the final stop bit completes.

Behaviour:
- Reset (reset=0, async): Tx=IDLE_LEVEL, TxBEN=0, rSetTxIFG=0, TxBusy=0, state=IDLE, shift register and counters cleared. An abort mid-frame drives Tx idle immediately.
- Edge detect: register BITCLK into bclk_q. tick = BITCLK & ~bclk_q, one MCLK wide. All bit advances happen on the MCLK edge after tick is seen.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE:
  - If TxIFG==0: latch TxData, wUCPEN, wUCPAR, wUCMSB, wUC7BIT and wUCSPB into shadow registers.
  - Pulse rSetTxIFG for 1 cycle, set TxBEN=1 and TxBusy=1, go to START. Tx stays idle until the next tick.
  - Configuration changes after the load do not affect the frame in flight.
- START: on tick, Tx=~IDLE_LEVEL and go to DATA with bitcnt = 7 or 6 (7-bit mode).
- DATA:
  - On each tick, drive the next bit: LSB-first shifts right from bit0; MSB-first starts at bit7, or bit6 in 7-bit mode.
  - Accumulate XOR parity.
  - After the last data bit's tick, go to PARITY if the latched PEN=1, else STOP1.
- PARITY:
  - On tick, Tx = ^data XOR ~PAR, so odd parity makes the total count of ones odd.
  - Example: 0x55 with odd parity sends 1.
- STOP1: on tick, Tx=IDLE_LEVEL, then go to STOP2 if SPB=1, else go to end-of-frame.
- STOP2: on tick, Tx=IDLE_LEVEL, then go to end-of-frame.
- End-of-frame: the tick after the last stop bit, i.e. the stop bit has lasted a full bit period.
  - If TxIFG==0: reload, pulse rSetTxIFG, and drive the start bit on this same tick. Back-to-back frames have no idle gap.
  - Otherwise: state=IDLE, TxBusy=0, TxBEN=0 on the next cycle.
- Frame length in ticks: 1 + (7|8) + PEN + (1|2). That gives 9 to 12 bit periods plus one wait tick from load.
- TxIFG going low while busy is ignored until end-of-frame. rSetTxIFG never pulses more than once per frame.
- A tick coincident with the load cycle in IDLE is not consumed; the start bit waits for the next tick.

Optional Feature:
TX_BREAK_EN
- With the macro defined: add input wUCTXBRK.
  - If it is high at load, the frame is sent with all data and parity bits forced to 0, TxData is ignored, and the stop bits are normal.
  - rSetTxIFG still pulses.
- Without the macro: no such port exists and data is always taken from TxData.

Decomposition:
- Shared package/include, with the other eUSCI parameters: state encodings, bit-count constants (DATA8=8, DATA7=7), parity encodings (PAR_ODD=0, PAR_EVEN=1), IDLE_LEVEL default.
- One natural sub-module: bitclk_edge_detect, the BITCLK rising-edge pulse generator, reusable by the receive path.

Test Plan:
- 8N1, LSB-first, TxData=0xA5, TxIFG=0 → rSetTxIFG pulses once; Tx sequence 0,1,0,1,0,0,1,0,1,1 on successive ticks; TxBusy falls after 10 bit periods.
- 8O2, LSB-first, 0x55 → bits 0, 1,0,1,0,1,0,1,0, parity 1, stop 1,1; 12 periods. Repeat with 0xA4 → parity 0.
- 8E1, MSB-first, 0x34 → bits 0, 0,0,1,1,0,1,0,0, parity 1, stop 1. Change wUCMSB mid-frame → frame is unchanged.
- 7N1, LSB-first, TxData=0xDA → only 0x5A[6:0] is sent (0,0,1,0,1,1,0,1), then stop; 9 periods.
- Back-to-back: TxIFG held low across two frames (0x1F then 0xF0) → start bit follows stop with no gap; two rSetTxIFG pulses.
- reset=0 during DATA → Tx=1, TxBusy=0, TxBEN=0 in the same time step. After release with TxIFG=1 → stays IDLE.
